// File: rtl/t07_mem_handler.sv
// t07_mem_handler
// Data-memory access sequencer between the control unit/ALU and an external
// memory bus. One load or store becomes one bus transaction; the core is held
// with `freeze` until it completes. Stores are lane-steered onto the 32-bit
// bus. Loads are lane-extracted and sign- or zero-extended into `load_data`.
//
// Ports
//   clk, nRst               clock, synchronous active-low reset
//   memRead, memWrite       direction strobes from control
//   memOp[3:0]              1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
//   addr[31:0]              effective address from the ALU
//   store_data[31:0]        rs2 value for stores
//   load_data[31:0]         formatted load result, held until the next good load
//   freeze                  stall request to PC / register file
//   done                    one-cycle completion pulse
//   misaligned, bus_err     one-cycle status pulses, concurrent with done
//   bus_addr/wdata/sel      word address, steered write data, byte enables
//   bus_read, bus_write     one-cycle request strobes
//   bus_rdata, bus_busy     memory read data and busy indication
//   state_dbg[1:0]          current sequencer state
//
// Bus handshake: a request is a single-cycle bus_read/bus_write strobe with
// bus_addr/bus_sel/bus_wdata valid and held stable until the transaction ends.
// The first following cycle with bus_busy low completes it, and bus_rdata is
// sampled in that cycle. While bus_busy stays high the sequencer waits, up to
// TIMEOUT_CYCLES + 1 cycles, then abandons the access with bus_err.
module t07_mem_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [3:0]  memOp,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic [1:0]  state_dbg
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Latched transaction context
  logic [3:0] op_q;
  logic [1:0] lo_q;
  logic       load_q;
  logic [7:0] cnt;
  logic       mis_q;
  logic       err_q;

  // Request decode
  logic is_load, is_store, req;
  logic op_half, op_word, mis_now;
  logic [3:0]  sel_now;
  logic [31:0] wdata_now;

  // FSM side effects on the datapath registers
  logic latch_req, set_mis, cnt_clr, cnt_inc, set_err, load_en;

  // Load formatting
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_fmt;

  assign is_load  = memRead & ~memWrite & (memOp >= OP_LB) & (memOp <= OP_LHU);
  assign is_store = memWrite & ~memRead & (memOp >= OP_SB) & (memOp <= OP_SW);
  // Gating with nRst keeps freeze low while reset is held.
  assign req      = nRst & (is_load | is_store);

  assign op_half = (memOp == OP_LH) | (memOp == OP_LHU) | (memOp == OP_SH);
  assign op_word = (memOp == OP_LW) | (memOp == OP_SW);
  assign mis_now = (op_half & addr[0]) | (op_word & (addr[1:0] != 2'b00));

  always_comb begin
    sel_now = 4'b1111;
    case (memOp)
      OP_LB, OP_LBU, OP_SB: sel_now = 4'b0001 << addr[1:0];
      OP_LH, OP_LHU, OP_SH: sel_now = addr[1] ? 4'b1100 : 4'b0011;
      default:              sel_now = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_now = 32'h0;
    case (memOp)
      OP_SB:   wdata_now = {4{store_data[7:0]}};
      OP_SH:   wdata_now = {2{store_data[15:0]}};
      OP_SW:   wdata_now = store_data;
      default: wdata_now = 32'h0;
    endcase
  end

  assign byte_v = bus_rdata[{lo_q, 3'b000} +: 8];
  assign half_v = bus_rdata[{lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt = bus_rdata;
    case (op_q)
      OP_LB:   load_fmt = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_fmt = {24'h0, byte_v};
      OP_LH:   load_fmt = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_fmt = {16'h0, half_v};
      default: load_fmt = bus_rdata;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_n    = state;
    freeze     = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    latch_req  = 1'b0;
    set_mis    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    set_err    = 1'b0;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          // Combinational so the PC holds in the request cycle itself.
          freeze = 1'b1;
          if (mis_now) begin
            set_mis = 1'b1;
            state_n = DONE;
          end else begin
            latch_req = 1'b1;
            state_n   = REQ;
          end
        end
      end
      REQ: begin
        freeze    = 1'b1;
        bus_read  = load_q;
        bus_write = ~load_q;
        cnt_clr   = 1'b1;
        state_n   = WAIT;
      end
      WAIT: begin
        freeze = 1'b1;
        if (!bus_busy) begin
          load_en = load_q;
          state_n = DONE;
        end else if (cnt == TMO_LIM) begin
          // Reached on WAIT cycle TIMEOUT_CYCLES + 1.
          set_err = 1'b1;
          state_n = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        // The same instruction is still presented here, so inputs are ignored.
        done       = 1'b1;
        misaligned = mis_q;
        bus_err    = err_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= IDLE;
      op_q      <= 4'h0;
      lo_q      <= 2'b00;
      load_q    <= 1'b0;
      cnt       <= 8'h0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_sel   <= 4'h0;
      load_data <= 32'h0;
    end else begin
      state <= state_n;
      if (latch_req) begin
        op_q      <= memOp;
        lo_q      <= addr[1:0];
        load_q    <= is_load;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wdata <= wdata_now;
        bus_sel   <= sel_now;
        mis_q     <= 1'b0;
        err_q     <= 1'b0;
      end
      if (set_mis) begin
        mis_q <= 1'b1;
        err_q <= 1'b0;
      end
      if (cnt_clr) cnt <= 8'h0;
      if (cnt_inc) cnt <= cnt + 8'd1;
      if (set_err) err_q <= 1'b1;
      if (load_en) load_data <= load_fmt;
    end
  end

  assign state_dbg = state;

endmodule
